residual_shortcut: RTL and testbench

//  Downstream of the 3x3 window generator. Captures the 2x2 shortcut taps (res) on every stride-2 window and

---
 rtl/residual_shortcut.sv | 125 ++++++++++++
 tb/tb_residual_shortcut.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/residual_shortcut.sv
// Residual shortcut path: 2x2 average-pools the shortcut taps of each stride-2 window, queues the pooled
// vectors, and adds each one to the matching conv result with 16-bit saturation.
module residual_shortcut #(
    parameter int FM_DEPTH   = 64,
    parameter int OUT_DEPTH  = 128,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                verticle_sync,
    input  logic                                mode_in,
    input  logic                                res_valid,
    input  logic [FM_DEPTH-1:0][3:0][15:0]      res,
    input  logic                                conv_valid,
    input  logic [OUT_DEPTH-1:0][15:0]          conv_in,
    output logic                                data_out_valid,
    output logic [OUT_DEPTH-1:0][15:0]          data_out,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

    logic [FM_DEPTH-1:0][15:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [LVL_W-1:0]           r_level;
    logic                       r_overflow;
    logic                       r_underflow;
    logic                       r_valid;
    logic [OUT_DEPTH-1:0][15:0] r_data;

    logic                       w_flush;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_push_ok;
    logic                       w_pop_ok;
    logic [FM_DEPTH-1:0][15:0]  w_pooled;
    logic [FM_DEPTH-1:0][15:0]  w_head;
    logic [OUT_DEPTH-1:0][15:0] w_sat;

    assign w_flush   = verticle_sync | ~mode_in;
    assign w_full    = (r_level == FULL_LEVEL);
    assign w_empty   = (r_level == '0);
    assign w_push    = res_valid & ~w_flush;
    assign w_pop     = conv_valid & ~w_flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push_ok = w_push & (~w_full | conv_valid);
    assign w_pop_ok  = w_pop & ~w_empty;
    assign w_head    = r_mem[r_rd_ptr];

    for (genvar c = 0; c < FM_DEPTH; c++) begin : g_pool
        logic [17:0] w_sum;
        assign w_sum = {{2{res[c][0][15]}}, res[c][0]} + {{2{res[c][1][15]}}, res[c][1]}
                     + {{2{res[c][2][15]}}, res[c][2]} + {{2{res[c][3][15]}}, res[c][3]};
        assign w_pooled[c] = w_sum[17:2];
    end

    for (genvar c = 0; c < OUT_DEPTH; c++) begin : g_sum
        logic [15:0] w_short;
        logic [16:0] w_add;
        if (c < FM_DEPTH) begin : g_tap
            assign w_short = w_pop_ok ? w_head[c] : 16'd0;
        end else begin : g_pad
            assign w_short = 16'd0;
        end
        assign w_add    = {conv_in[c][15], conv_in[c]} + {w_short[15], w_short};
        assign w_sat[c] = (w_add[16] != w_add[15]) ? (w_add[16] ? 16'h8000 : 16'h7FFF) : w_add[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[r_wr_ptr] <= w_pooled;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
        end else if (w_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= r_level + LVL_W'(w_push_ok) - LVL_W'(w_pop_ok);
            if (w_push && w_full && !conv_valid) begin
                r_overflow <= 1'b1;
            end
            if (w_pop && w_empty) begin
                r_underflow <= 1'b1;
            end
            r_valid <= w_pop;
            if (w_pop) begin
                r_data <= w_sat;
            end
        end
    end

    assign data_out_valid = r_valid;
    assign data_out       = r_data;
    assign fifo_level     = r_level;
    assign overflow       = r_overflow;
    assign underflow      = r_underflow;

endmodule

// File: tb/tb_residual_shortcut.sv
// Self-checking bench for residual_shortcut: directed scenarios followed by a random phase, all compared
// against a queue-based reference model computed with plain integer arithmetic.
module tb_residual_shortcut;

    localparam int FM  = 64;
    localparam int OUT = 128;
    localparam int FD  = 8;

    typedef logic [FM-1:0][15:0]  pvec_t;
    typedef logic [OUT-1:0][15:0] ovec_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   vs;
    logic                   mode;
    logic                   resValid;
    logic [FM-1:0][3:0][15:0] res;
    logic                   convValid;
    ovec_t                  convIn;
    logic                   dataOutValid;
    ovec_t                  dataOut;
    logic [3:0]             fifoLevel;
    logic                   overflow;
    logic                   underflow;

    pvec_t q[$];
    ovec_t expData;
    logic  expValid;
    logic  expOvf;
    logic  expUnf;
    int    checks = 0;
    int    errors = 0;

    residual_shortcut #(.FM_DEPTH(FM), .OUT_DEPTH(OUT), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .verticle_sync(vs), .mode_in(mode),
        .res_valid(resValid), .res(res), .conv_valid(convValid), .conv_in(convIn),
        .data_out_valid(dataOutValid), .data_out(dataOut), .fifo_level(fifoLevel),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic int floorDiv4(input int s);
        if (s >= 0) return s / 4;
        return -((-s + 3) / 4);
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic pvec_t poolRef(input logic [FM-1:0][3:0][15:0] taps);
        pvec_t r;
        int s;
        for (int c = 0; c < FM; c++) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += int'($signed(taps[c][k]));
            r[c] = 16'(floorDiv4(s));
        end
        return r;
    endfunction

    // Reference model: pop is taken before push, which gives both the full and the empty same-cycle rules.
    task automatic modelStep();
        pvec_t head;
        int sh;
        if (rst) begin
            q.delete();
            expOvf = 0; expUnf = 0; expValid = 0; expData = '0;
        end else if (vs || !mode) begin
            q.delete();
            expOvf = 0; expUnf = 0; expValid = 0;
        end else begin
            expValid = convValid;
            if (convValid) begin
                if (q.size() > 0) head = q.pop_front();
                else begin head = '0; expUnf = 1; end
                for (int c = 0; c < OUT; c++) begin
                    if (c < FM) sh = int'($signed(head[c]));
                    else sh = 0;
                    expData[c] = 16'(sat16(int'($signed(convIn[c])) + sh));
                end
            end
            if (resValid) begin
                if (q.size() < FD) q.push_back(poolRef(res));
                else expOvf = 1;
            end
        end
    endtask

    task automatic checkVal(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int bad;
        checkVal("level", int'(fifoLevel), q.size());
        checkVal("valid", int'(dataOutValid), int'(expValid));
        checkVal("overflow", int'(overflow), int'(expOvf));
        checkVal("underflow", int'(underflow), int'(expUnf));
        bad = 0;
        for (int c = OUT - 1; c >= 0; c--) if (dataOut[c] !== expData[c]) bad = c;
        checks++;
        assert (dataOut === expData) else begin
            errors++;
            $error("[TB] FAIL data_out ch%0d: observed %0d expected %0d", bad,
                   $signed(dataOut[bad]), $signed(expData[bad]));
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic idle();
        rst = 0; vs = 0; resValid = 0; convValid = 0;
    endtask

    task automatic randRes();
        for (int c = 0; c < FM; c++) for (int k = 0; k < 4; k++) res[c][k] = 16'($urandom);
    endtask

    task automatic randConv();
        for (int c = 0; c < OUT; c++) convIn[c] = 16'($urandom);
    endtask

    initial begin
        rst = 1; vs = 0; mode = 0; resValid = 0; convValid = 0; res = '0; convIn = '0;
        q.delete(); expData = '0; expValid = 0; expOvf = 0; expUnf = 0;
        applyStimulus();
        checkVal("reset level", int'(fifoLevel), 0);

        // Basic push then pop
        idle(); mode = 1; applyStimulus();
        res = '0; res[0] = {16'd16, 16'd12, 16'd8, 16'd4}; resValid = 1;
        applyStimulus();
        checkVal("t1 level", int'(fifoLevel), 1);
        idle(); convValid = 1; convIn = '0; convIn[0] = 16'd100;
        applyStimulus();
        checkVal("t1 data0", int'($signed(dataOut[0])), 110);
        checkVal("t1 valid", int'(dataOutValid), 1);
        idle(); applyStimulus();
        checkVal("t1 valid pulse", int'(dataOutValid), 0);

        // Floor rounding and zero padding
        res = '0; res[0] = {16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF}; resValid = 1;
        applyStimulus();
        idle(); convValid = 1; convIn = '0; convIn[FM] = 16'd7;
        applyStimulus();
        checkVal("t2 floor", int'($signed(dataOut[0])), -2);
        checkVal("t2 pad", int'($signed(dataOut[FM])), 7);

        // Saturation both directions
        idle(); res = '0;
        res[0] = {4{16'd32000}}; res[1] = {4{16'h8000}}; resValid = 1;
        applyStimulus();
        idle(); convValid = 1; convIn = '0; convIn[0] = 16'd1000; convIn[1] = 16'hFFFB;
        applyStimulus();
        checkVal("t3 sat hi", int'($signed(dataOut[0])), 32767);
        checkVal("t3 sat lo", int'($signed(dataOut[1])), -32768);

        // Fill, overflow, full push+pop, drain in order
        idle();
        for (int i = 0; i < FD; i++) begin randRes(); resValid = 1; applyStimulus(); end
        checkVal("t4 full", int'(fifoLevel), 8);
        randRes(); applyStimulus();
        checkVal("t4 overflow", int'(overflow), 1);
        checkVal("t4 level hold", int'(fifoLevel), 8);
        randRes(); randConv(); convValid = 1; applyStimulus();
        checkVal("t4 full pushpop", int'(fifoLevel), 8);
        resValid = 0;
        for (int i = 0; i < FD; i++) begin randConv(); applyStimulus(); end
        checkVal("t4 drained", int'(fifoLevel), 0);

        // Underflow and empty push+pop
        idle(); vs = 1; applyStimulus();
        idle(); convValid = 1; convIn = '0; convIn[0] = 16'd55; applyStimulus();
        checkVal("t5 underflow data", int'($signed(dataOut[0])), 55);
        checkVal("t5 underflow", int'(underflow), 1);
        randRes(); randConv(); resValid = 1; applyStimulus();
        checkVal("t5 empty pushpop", int'(fifoLevel), 1);

        // Flush, mode gating, mid-burst reset
        idle(); vs = 1; applyStimulus();
        idle();
        for (int i = 0; i < 3; i++) begin randRes(); resValid = 1; applyStimulus(); end
        checkVal("t6 level3", int'(fifoLevel), 3);
        idle(); vs = 1; applyStimulus();
        checkVal("t6 flush level", int'(fifoLevel), 0);
        idle(); randConv(); convValid = 1; applyStimulus();
        checkVal("t6 post-flush underflow", int'(underflow), 1);
        idle(); mode = 0; randRes(); resValid = 1; applyStimulus();
        checkVal("t6 mode0 level", int'(fifoLevel), 0);
        idle(); mode = 1;
        for (int i = 0; i < 3; i++) begin randRes(); randConv(); resValid = 1; convValid = (i == 2); applyStimulus(); end
        rst = 1; resValid = 1; convValid = 1; applyStimulus();
        checkVal("t6 reset level", int'(fifoLevel), 0);
        checkVal("t6 reset data", int'(dataOut[0]), 0);

        // Random traffic
        idle();
        for (int i = 0; i < 400; i++) begin
            randRes(); randConv();
            resValid  = ($urandom_range(0, 99) < 55);
            convValid = ($urandom_range(0, 99) < 45);
            vs        = ($urandom_range(0, 59) == 0);
            mode      = ($urandom_range(0, 49) != 0);
            rst       = ($urandom_range(0, 149) == 0);
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
